square_table_writer: RTL
========================

# square_table_writer

Writer side of the square-root test flow. Accepts a stream of 4-bit roots over a valid/ready handshake and computes each square by successive odd-number addition (1+3+5+…). It writes the 8-bit squares into a 16x8 table RAM at consecutive addresses 0..15, then asserts Done. The filled table is the stimulus image the square-root datapath later reads. An external read port allows the bench or a downstream reader to inspect contents.

## Interface
- DEPTH, 16: table words; address width 4.
- CLK  in  1  rising-edge clock
- ResetN  in  1  reset, asynchronous, active-low
- St  in  1  start pulse/level; sampled in IDLE and DONE only
- Vld  in  1  Root valid
- Root  in  4  value to square
- Rdy  out  1  block accepts Root this cycle
- Busy  out  1  high in any state other than IDLE/DONE
- Done  out  1  all DEPTH words written
- WrAddr  out  4  current write pointer
- Square  out  8  last value written
- RdAddr  in  4  external read address
- RdData  out  8  registered read data

## Operation
- States: IDLE, FETCH, ACCUM, WRITE, DONE.
- IDLE: Rdy=0, Done=0. St=1 -> FETCH, WrAddr<=0.
- FETCH: Rdy=1. Vld&Rdy -> latch cnt<=Root, acc<=0, odd<=1 -> ACCUM. Vld=0 -> stay; no timeout.
- ACCUM: cnt!=0 -> acc<=acc+odd, odd<=odd+2, cnt<=cnt-1, stay. cnt==0 -> WRITE.
- WRITE: RAM[WrAddr]<=acc, Square<=acc. WrAddr==15 -> WrAddr<=0, DONE. Otherwise WrAddr<=WrAddr+1, FETCH.
- DONE: Done=1, held until St. St=1 -> FETCH with WrAddr=0 and Done cleared on that edge. The table is overwritten from address 0.
- St in FETCH/ACCUM/WRITE is ignored.
- Arithmetic: acc 8-bit unsigned. Max 15²=225, so no overflow. odd 8-bit, max 31.
- Read port: RdData<=RAM[RdAddr] every edge, independent of state. Read/write to the same address in the same cycle returns old data (read-before-write).
- RAM contents are not reset.

## Timing
- Reset values: Rdy=0, Busy=0, Done=0, WrAddr=0, Square=0, RdData=0. State=IDLE, cnt/acc/odd=0.
- Reset asserted mid-operation: immediate return to IDLE. Words already written stay valid; no partial write occurs.
- Accept on edge k. ACCUM occupies cycles k+1..k+Root+1. WRITE is at cycle k+Root+2, and the RAM update takes effect at its closing edge. Rdy returns at cycle k+Root+3.
- Per-word latency is Root+2 cycles with Rdy low. Full table = Σ(Root_i+2) + 16 handshake cycles minimum.
- Done rises the cycle after the WRITE of address 15.
- RdData is valid one cycle after RdAddr.

## Structure
- Package sqtab_pkg:
  - DEPTH, ADDR_W=4, ROOT_W=4, SQ_W=8
  - state enum IDLE/FETCH/ACCUM/WRITE/DONE
  - ODD_INIT=1, ODD_STEP=2
- Sub-module sqtab_ram:
  - 16x8 synchronous RAM: one write port (addr, data, we) and one registered read port.
  - Read-before-write.
  - ramstyle attribute for block RAM.
- Top contains the FSM, pointer and accumulator only.

## Test plan
- Ramp Root=0..15 back-to-back with Vld held high -> Done asserted. Reads of addr 0..15 return 0,1,4,9,…,196,225.
- Root=15 single word: accept at edge k -> Rdy low for 17 cycles. RAM[0]=225 readable via RdAddr=0 two cycles after WRITE.
- Vld toggled low for 5 cycles between words -> FSM holds FETCH. WrAddr is unchanged and contents are correct.
- St pulsed during ACCUM -> no effect. ResetN pulsed low mid-ACCUM at word 7 -> IDLE with all outputs zero. Words 0..6 are intact, word 7 is unchanged.
- After Done, St with Root stream of all 3s -> every address reads 9 and Done reasserts. St held continuously in DONE restarts exactly once per DONE entry.
- RdAddr=WrAddr during WRITE -> RdData shows old value that cycle and new value on the next read.

Source files
------------

// File: rtl/sqtab_pkg.sv
// Shared types and constants for the square table writer.
// Widths, FSM states and odd-sequence parameters.
package sqtab_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int ROOT_W = 4;
  localparam int SQ_W   = 8;

  localparam logic [SQ_W-1:0] ODD_INIT = 8'd1;
  localparam logic [SQ_W-1:0] ODD_STEP = 8'd2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ACCUM,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/square_table_writer_if.sv
// Root stream handshake between a producer and the writer.
// Master drives Vld/Root; slave returns Rdy.
interface square_table_writer_if
  import sqtab_pkg::*;
();

  logic              Vld;
  logic [ROOT_W-1:0] Root;
  logic              Rdy;

  modport master (
    output Vld,
    output Root,
    input  Rdy
  );

  modport slave (
    input  Vld,
    input  Root,
    output Rdy
  );

endinterface

// File: rtl/sqtab_ram.sv
// 16x8 table RAM, one write port, one registered read port.
// A read and write to one address in a cycle returns old data.
module sqtab_ram
  import sqtab_pkg::*;
(
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [SQ_W-1:0]   i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [SQ_W-1:0]   o_rd_data
);

  (* ramstyle = "M9K" *)
  logic [SQ_W-1:0] r_mem [DEPTH];

  logic [SQ_W-1:0] r_rd_data;

  // Array write; contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read samples the array before any same-edge write.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/square_table_writer.sv
// Squares a stream of roots by odd-number addition and
// fills a 16-entry table from address 0 upward.
module square_table_writer
  import sqtab_pkg::*;
(
  input  logic                 CLK,
  input  logic                 ResetN,
  input  logic                 St,
  square_table_writer_if.slave s_if,
  output logic                 Busy,
  output logic                 Done,
  output logic [ADDR_W-1:0]    WrAddr,
  output logic [SQ_W-1:0]      Square,
  input  logic [ADDR_W-1:0]    RdAddr,
  output logic [SQ_W-1:0]      RdData
);

  state_t r_state;
  state_t w_next;

  logic [ROOT_W-1:0] r_cnt;
  logic [SQ_W-1:0]   r_acc;
  logic [SQ_W-1:0]   r_odd;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [SQ_W-1:0]   r_square;

  logic w_rdy;
  logic w_accept;
  logic w_we;
  logic w_last;
  logic w_start;

  assign w_rdy    = (r_state == FETCH);
  assign w_accept = w_rdy && s_if.Vld;
  assign w_we     = (r_state == WRITE);
  assign w_last   = (r_wr_addr == ADDR_W'(DEPTH - 1));
  assign w_start  = St &&
                    ((r_state == IDLE) ||
                     (r_state == DONE));

  // State register.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; St only matters in IDLE and DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (St) w_next = FETCH;
      end
      FETCH: begin
        if (s_if.Vld) w_next = ACCUM;
      end
      ACCUM: begin
        if (r_cnt == '0) w_next = WRITE;
      end
      WRITE: begin
        w_next = w_last ? DONE : FETCH;
      end
      DONE: begin
        if (St) w_next = FETCH;
      end
      default: w_next = IDLE;
    endcase
  end

  // Accumulator: sum of the first cnt odd numbers.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_odd <= '0;
    end else if (w_accept) begin
      r_cnt <= s_if.Root;
      r_acc <= '0;
      r_odd <= ODD_INIT;
    end else if (r_state == ACCUM && r_cnt != '0) begin
      r_cnt <= r_cnt - ROOT_W'(1);
      r_acc <= r_acc + r_odd;
      r_odd <= r_odd + ODD_STEP;
    end
  end

  // Write pointer and last-written square.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      r_wr_addr <= '0;
      r_square  <= '0;
    end else if (w_start) begin
      r_wr_addr <= '0;
    end else if (w_we) begin
      r_square  <= r_acc;
      r_wr_addr <= w_last ? '0 :
                   r_wr_addr + ADDR_W'(1);
    end
  end

  sqtab_ram u_ram (
    .CLK       (CLK),
    .ResetN    (ResetN),
    .i_we      (w_we),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (r_acc),
    .i_rd_addr (RdAddr),
    .o_rd_data (RdData)
  );

  assign s_if.Rdy = w_rdy;
  assign Busy     = (r_state == FETCH) ||
                    (r_state == ACCUM) ||
                    (r_state == WRITE);
  assign Done     = (r_state == DONE);
  assign WrAddr   = r_wr_addr;
  assign Square   = r_square;

endmodule
